apb_uart_csr: RTL and testbench

Parametrised APB control/status slave for the next-generation UART. Decodes a six-register map and generates configurable APB wait states with error response. Drives the TX/RX FIFO handshakes and produces `baud_en_16x`/`baud_en` from a software-programmable divisor. Raises a maskable, level `irq` from FIFO thresholds and sticky RX error and overrun flags. It sits between the APB bus and the existing `fifo`/`uart_tx`/`uart_rx` instances, replacing the hard-coded divisor table and fixed zero-wait decode.

---
 rtl/apb_uart_csr.sv | 132 +++++++++++++
 tb/tb_apb_uart_csr.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_csr.sv
// apb_uart_csr: APB control/status slave for the UART with wait states, FIFO strobes, baud ticks and interrupts
module apb_uart_csr #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int WAIT_STATES = 0,
  parameter int DIV_WIDTH   = 16,
  parameter int DIV_RESET   = 27,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  output logic                  tx_wr_en,
  output logic [7:0]            tx_wdata,
  input  logic                  tx_full,
  input  logic [CNT_WIDTH-1:0]  tx_count,
  output logic                  rx_rd_en,
  input  logic [7:0]            rx_rdata,
  input  logic                  rx_empty,
  input  logic                  rx_full,
  input  logic [CNT_WIDTH-1:0]  rx_count,
  input  logic                  rx_ready,
  input  logic                  rx_error,
  input  logic                  tx_busy,
  output logic                  tx_en,
  output logic                  rx_en,
  output logic                  baud_en_16x,
  output logic                  baud_en,
  output logic                  irq
);
  localparam logic [ADDR_WIDTH-1:0] A_DATA = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_INT  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_DIV  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_THR  = ADDR_WIDTH'(5);
  logic [2:0]            r_wait_cnt;
  logic [4:0]            r_ctrl;
  logic [DIV_WIDTH-1:0]  r_div, r_div_cnt;
  logic [3:0]            r_os_cnt;
  logic [CNT_WIDTH-1:0]  r_rx_thr, r_tx_thr;
  logic                  r_err, r_ovr, r_irq;
  logic                  w_access, w_done, w_err, w_wr, w_rd, w_w1c, w_div_wr;
  logic                  w_rxthr, w_txthr, w_run;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_access = PSELx && PENABLE;
  assign PREADY   = PRESET || !w_access || r_wait_cnt == 3'(WAIT_STATES);
  // reset in the completion cycle aborts the transfer, so nothing may fire
  assign w_done   = w_access && PREADY && !PRESET;
  assign w_err    = PADDR > A_THR || (PWRITE && PADDR == A_STAT) ||
                    (PADDR == A_DATA && (PWRITE ? tx_full : rx_empty)) ||
                    (PWRITE && PADDR == A_DIV && PWDATA[DIV_WIDTH-1:0] < DIV_WIDTH'(2));
  assign w_wr     = w_done && !w_err && PWRITE;
  assign w_rd     = w_done && !w_err && !PWRITE;
  assign w_w1c    = w_wr && PADDR == A_INT;
  assign w_div_wr = w_wr && PADDR == A_DIV;
  assign tx_wr_en = w_wr && PADDR == A_DATA;
  assign rx_rd_en = w_rd && PADDR == A_DATA;
  assign tx_wdata = PWDATA[7:0];
  assign PSLVERR  = w_done && w_err;
  assign PRDATA   = w_rd ? w_rdata : '0;
  assign w_rxthr  = r_rx_thr != '0 && rx_count >= r_rx_thr;
  assign w_txthr  = tx_count <= r_tx_thr;
  assign tx_en    = r_ctrl[0];
  assign rx_en    = r_ctrl[1];
  assign irq      = r_irq;

  always_comb begin
    w_rdata = '0;
    case (PADDR)
      A_DATA: w_rdata[7:0] = rx_rdata;
      A_CTRL: w_rdata[4:0] = r_ctrl;
      A_STAT: w_rdata[3:0] = {r_irq, tx_busy, rx_empty, tx_full};
      A_INT:  w_rdata[3:0] = {r_ovr, r_err, w_txthr, w_rxthr};
      A_DIV:  w_rdata[DIV_WIDTH-1:0] = r_div;
      A_THR: begin
        w_rdata[CNT_WIDTH-1:0] = r_rx_thr;
        w_rdata[CNT_WIDTH+7:8] = r_tx_thr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET || (PSELx && !PENABLE)) r_wait_cnt <= '0;
    else if (w_access && !PREADY) r_wait_cnt <= r_wait_cnt + 3'd1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_ctrl   <= '0;
      r_div    <= DIV_WIDTH'(DIV_RESET);
      r_rx_thr <= '0;
      r_tx_thr <= '0;
      r_err    <= 1'b0;
      r_ovr    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && PADDR == A_CTRL) r_ctrl <= PWDATA[4:0];
      if (w_div_wr) r_div <= PWDATA[DIV_WIDTH-1:0];
      if (w_wr && PADDR == A_THR) begin
        r_rx_thr <= PWDATA[CNT_WIDTH-1:0];
        r_tx_thr <= PWDATA[CNT_WIDTH+7:8];
      end
      r_err <= rx_error || (r_err && !(w_w1c && PWDATA[2]));
      r_ovr <= (rx_ready && rx_full) || (r_ovr && !(w_w1c && PWDATA[3]));
      r_irq <= (w_rxthr && r_ctrl[2]) || (w_txthr && r_ctrl[3]) || ((r_err || r_ovr) && r_ctrl[4]);
    end
  end

  assign w_run       = r_ctrl[0] || r_ctrl[1];
  assign baud_en_16x = w_run && r_div_cnt == r_div - DIV_WIDTH'(1);
  assign baud_en     = baud_en_16x && r_os_cnt == 4'hF;

  always_ff @(posedge PCLK) begin
    if (PRESET || !w_run || w_div_wr) begin
      r_div_cnt <= '0;
      r_os_cnt  <= '0;
    end else if (baud_en_16x) begin
      r_div_cnt <= '0;
      r_os_cnt  <= r_os_cnt + 4'd1;
    end else r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
  end
endmodule

// File: tb/tb_apb_uart_csr.sv
// tb_apb_uart_csr: table vectors, directed corner sequences and a randomized run against a register-map model
module tb_apb_uart_csr;
  localparam int WS = 2;
  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic [3:0]  PADDR = '0;
  logic        PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [15:0] PWDATA = '0, PRDATA;
  logic        PREADY, PSLVERR, tx_wr_en, rx_rd_en, tx_en, rx_en, baud_en_16x, baud_en, irq;
  logic [7:0]  tx_wdata, rx_rdata = 8'h3C;
  logic        tx_full = 1'b0, rx_empty = 1'b1, rx_full = 1'b0;
  logic [4:0]  tx_count = 5'd5, rx_count = 5'd0;
  logic        rx_ready = 1'b0, rx_error = 1'b0, tx_busy = 1'b0;

  apb_uart_csr #(.WAIT_STATES(WS)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .tx_wr_en(tx_wr_en), .tx_wdata(tx_wdata), .tx_full(tx_full), .tx_count(tx_count),
    .rx_rd_en(rx_rd_en), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_full(rx_full),
    .rx_count(rx_count), .rx_ready(rx_ready), .rx_error(rx_error), .tx_busy(tx_busy),
    .tx_en(tx_en), .rx_en(rx_en), .baud_en_16x(baud_en_16x), .baud_en(baud_en), .irq(irq));

  always #5 PCLK = ~PCLK;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [15:0] g_rd;
  logic [7:0]  g_wdata;
  logic        g_err, g_txen_done;
  int          g_waits, g_ntx, g_nrx, g_tdone;
  task automatic apb(input logic [3:0] a, input logic w, input logic [15:0] d);
    bit done = 0;
    @(posedge PCLK); #1;
    PADDR = a; PWRITE = w; PWDATA = d; PSELx = 1; PENABLE = 0;
    @(posedge PCLK); #1;
    PENABLE = 1;
    g_waits = 0; g_ntx = 0; g_nrx = 0; g_rd = 'x; g_err = 1'bx;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge PCLK);
      g_ntx += int'(tx_wr_en);
      g_nrx += int'(rx_rd_en);
      if (tx_wr_en) g_wdata = tx_wdata;
      if (PREADY) begin
        done = 1; g_rd = PRDATA; g_err = PSLVERR; g_tdone = cyc; g_txen_done = tx_en;
      end else g_waits++;
    end
    chk("apb_completes", 32'(done), 1);
    @(posedge PCLK); #1;
    PSELx = 0; PENABLE = 0;
  endtask

  task automatic wait_ev(input bit sel, input int lim, output int t);
    t = -1;
    for (int k = 0; k < lim && t < 0; k++) begin
      @(negedge PCLK);
      if (sel ? baud_en : baud_en_16x) t = cyc;
    end
  endtask

  // model of the software-visible state
  logic [4:0]  m_ctrl, m_rx_thr, m_tx_thr;
  logic [15:0] m_div;
  logic        m_err, m_ovr;
  function automatic logic m_rxthr(); return m_rx_thr != 0 && rx_count >= m_rx_thr; endfunction
  function automatic logic m_txthr(); return tx_count <= m_tx_thr; endfunction
  function automatic logic m_irq();
    return (m_rxthr() && m_ctrl[2]) || (m_txthr() && m_ctrl[3]) || ((m_err || m_ovr) && m_ctrl[4]);
  endfunction
  function automatic logic m_is_err(input int a, input logic w, input logic [15:0] d);
    if (a > 5) return 1;
    if (a == 2) return w;
    if (a == 0) return w ? tx_full : rx_empty;
    if (a == 4 && w) return d < 2;
    return 0;
  endfunction
  function automatic logic [15:0] m_read(input int a);
    case (a)
      0: return {8'h0, rx_rdata};
      1: return {11'h0, m_ctrl};
      2: return {12'h0, m_irq(), tx_busy, rx_empty, tx_full};
      3: return {12'h0, m_ovr, m_err, m_txthr(), m_rxthr()};
      4: return m_div;
      5: return {3'h0, m_tx_thr, 3'h0, m_rx_thr};
      default: return 16'h0;
    endcase
  endfunction

  typedef struct {
    logic [3:0] a; logic w; logic [15:0] d; logic txf; logic rxe;
    logic e; logic [15:0] rd; int ntx; int nrx;
  } vec_t;
  vec_t tbl [27];

  initial begin
    int t, t0;
    tbl[0]  = '{4'd4, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd27,   0, 0};
    tbl[1]  = '{4'd1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0};
    tbl[2]  = '{4'd3, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0};
    tbl[3]  = '{4'd5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0};
    tbl[4]  = '{4'd2, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0002, 0, 0};
    tbl[5]  = '{4'd2, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 0, 0};
    tbl[6]  = '{4'd2, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 0};
    tbl[7]  = '{4'd7, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 0};
    tbl[8]  = '{4'd6, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 0};
    tbl[9]  = '{4'd0, 1'b1, 16'h0055, 1'b1, 1'b1, 1'b1, 16'h0000, 0, 0};
    tbl[10] = '{4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 0};
    tbl[11] = '{4'd4, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 0};
    tbl[12] = '{4'd4, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 0};
    tbl[13] = '{4'd4, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd27,   0, 0};
    tbl[14] = '{4'd5, 1'b1, 16'h0A03, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0};
    tbl[15] = '{4'd5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0A03, 0, 0};
    tbl[16] = '{4'd3, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0002, 0, 0};
    tbl[17] = '{4'd5, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0};
    tbl[18] = '{4'd5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h1F1F, 0, 0};
    tbl[19] = '{4'd5, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0};
    tbl[20] = '{4'd0, 1'b1, 16'h01C3, 1'b0, 1'b1, 1'b0, 16'h0000, 1, 0};
    tbl[21] = '{4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h003C, 0, 1};
    tbl[22] = '{4'd1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0};
    tbl[23] = '{4'd1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h001F, 0, 0};
    tbl[24] = '{4'd1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0};
    tbl[25] = '{4'd3, 1'b1, 16'h000F, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0};
    tbl[26] = '{4'd3, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0};

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_pready", PREADY, 1); chk("rst_prdata", PRDATA, 0); chk("rst_pslverr", PSLVERR, 0);
    chk("rst_tx_en", tx_en, 0); chk("rst_rx_en", rx_en, 0); chk("rst_irq", irq, 0);
    chk("rst_ticks", {baud_en_16x, baud_en}, 0);
    chk("rst_strobes", {tx_wr_en, rx_rd_en}, 0);
    @(posedge PCLK); #1 PRESET = 0;

    // reset raised during the access phase of a CTRL write must abort it
    @(posedge PCLK); #1;
    PADDR = 4'd1; PWRITE = 1; PWDATA = 16'h3; PSELx = 1; PENABLE = 0;
    @(posedge PCLK); #1;
    PENABLE = 1; PRESET = 1;
    @(negedge PCLK);
    chk("abort_pready", PREADY, 1);
    chk("abort_pslverr", PSLVERR, 0);
    repeat (3) @(posedge PCLK);
    #1 PSELx = 0; PENABLE = 0; PRESET = 0;
    @(negedge PCLK);
    chk("abort_tx_en", tx_en, 0);

    foreach (tbl[i]) begin
      tx_full = tbl[i].txf; rx_empty = tbl[i].rxe;
      apb(tbl[i].a, tbl[i].w, tbl[i].d);
      chk($sformatf("v%0d_err", i), g_err, tbl[i].e);
      chk($sformatf("v%0d_rdata", i), g_rd, tbl[i].rd);
      chk($sformatf("v%0d_txpush", i), g_ntx, tbl[i].ntx);
      chk($sformatf("v%0d_rxpop", i), g_nrx, tbl[i].nrx);
      chk($sformatf("v%0d_waits", i), g_waits, WS);
    end
    chk("tx_wdata", g_wdata, 8'hC3);
    tx_full = 0; rx_empty = 1;

    // enable both cores, divisor at reset value
    apb(4'd1, 1, 16'h3);
    chk("ctrl_waits", g_waits, WS);
    chk("ctrl_not_yet", g_txen_done, 0);
    @(negedge PCLK);
    chk("ctrl_tx_en", tx_en, 1); chk("ctrl_rx_en", rx_en, 1);
    wait_ev(0, 100, t);  chk("div27_first16x", t - g_tdone, 27);
    t0 = t; wait_ev(0, 100, t); chk("div27_period16x", t - t0, 27);
    wait_ev(1, 600, t);  chk("div27_firstbaud", t - g_tdone, 432);
    t0 = t; wait_ev(1, 600, t); chk("div27_baudperiod", t - t0, 432);

    apb(4'd4, 1, 16'd4);
    chk("div4_err", g_err, 0);
    t0 = g_tdone;
    wait_ev(0, 50, t);  chk("div4_first16x", t - t0, 4);
    wait_ev(0, 50, t);  chk("div4_period16x", t - t0, 8);
    wait_ev(1, 200, t); chk("div4_firstbaud", t - t0, 64);
    wait_ev(1, 200, t); chk("div4_baudperiod", t - t0, 128);
    apb(4'd4, 0, 0); chk("div4_read", g_rd, 4);

    // overrun sticky: set, set-beats-W1C, clean clear
    apb(4'd1, 1, 16'h13);
    apb(4'd3, 1, 16'hC);
    @(posedge PCLK); #1 rx_full = 1; rx_ready = 1;
    @(posedge PCLK); #1 rx_ready = 0;
    @(negedge PCLK); chk("ovr_irq_lag", irq, 0);
    @(negedge PCLK); chk("ovr_irq", irq, 1);
    apb(4'd3, 0, 0); chk("ovr_int", g_rd, 16'h8);
    rx_ready = 1;
    apb(4'd3, 1, 16'h8);
    rx_ready = 0;
    apb(4'd3, 0, 0); chk("ovr_set_wins", g_rd, 16'h8);
    rx_full = 0;
    apb(4'd3, 1, 16'h8);
    @(negedge PCLK); chk("ovr_clr_irq_lag", irq, 1);
    @(negedge PCLK); chk("ovr_clr_irq", irq, 0);
    @(posedge PCLK); #1 rx_error = 1;
    @(posedge PCLK); #1 rx_error = 0;
    apb(4'd3, 0, 0); chk("err_int", g_rd, 16'h4);
    apb(4'd3, 1, 16'h4);
    apb(4'd3, 0, 0); chk("err_clr", g_rd, 16'h0);

    // RX threshold interrupt then a DATA pop
    apb(4'd1, 1, 16'h7);
    apb(4'd5, 1, 16'h3);
    rx_count = 2;
    repeat (3) @(negedge PCLK);
    chk("rxthr_below", irq, 0);
    @(posedge PCLK); #1 rx_count = 3;
    @(negedge PCLK); chk("rxthr_lag", irq, 0);
    @(negedge PCLK); chk("rxthr_irq", irq, 1);
    rx_rdata = 8'hA5; rx_empty = 0;
    apb(4'd0, 0, 0);
    chk("pop_err", g_err, 0); chk("pop_rdata", g_rd, 16'h00A5); chk("pop_pulses", g_nrx, 1);

    m_ctrl = 5'h7; m_div = 16'd4; m_rx_thr = 5'd3; m_tx_thr = 5'd0; m_err = 0; m_ovr = 0;
    for (int i = 0; i < 300; i++) begin
      int a;
      logic w, e_exp;
      logic [15:0] d, rd_exp;
      tx_full = 1'($urandom); rx_empty = 1'($urandom); rx_full = 1'($urandom);
      tx_count = 5'($urandom); rx_count = 5'($urandom); rx_rdata = 8'($urandom);
      tx_busy = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        logic e;
        e = 1'($urandom);
        @(posedge PCLK); #1 rx_ready = 1; rx_error = e;
        @(posedge PCLK); #1 rx_ready = 0; rx_error = 0;
        m_ovr |= rx_full; m_err |= e;
      end
      a = $urandom_range(0, 7);
      w = 1'($urandom);
      d = (a == 4) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      e_exp = m_is_err(a, w, d);
      rd_exp = (w || e_exp) ? 16'h0 : m_read(a);
      apb(4'(a), w, d);
      chk($sformatf("rnd%0d_a%0d_w%0d_err", i, a, w), g_err, e_exp);
      chk($sformatf("rnd%0d_a%0d_rdata", i, a), g_rd, rd_exp);
      chk($sformatf("rnd%0d_push", i), g_ntx, (a == 0 && w && !e_exp) ? 1 : 0);
      chk($sformatf("rnd%0d_pop", i), g_nrx, (a == 0 && !w && !e_exp) ? 1 : 0);
      if (w && !e_exp) begin
        if (a == 1) m_ctrl = d[4:0];
        if (a == 3) begin
          if (d[2]) m_err = 0;
          if (d[3]) m_ovr = 0;
        end
        if (a == 4) m_div = d;
        if (a == 5) begin
          m_rx_thr = d[4:0]; m_tx_thr = d[12:8];
        end
      end
      @(negedge PCLK); @(negedge PCLK);
      chk($sformatf("rnd%0d_irq", i), irq, m_irq());
      chk($sformatf("rnd%0d_en", i), {tx_en, rx_en}, {m_ctrl[0], m_ctrl[1]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
